// File: rtl/bt_pkg.sv
// Shared constants for the Bluefruit control-pad packet decoder.
// Holds FSM state encoding, ASCII framing bytes, checksum target and d-pad indices.
// Pure constants; no logic, no timing.
package bt_pkg;

    // Parser states, one per expected packet byte position
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TYPE = 3'd1;
    localparam logic [2:0] ST_BTN  = 3'd2;
    localparam logic [2:0] ST_ACT  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    // ASCII bytes used in control-pad framing
    localparam logic [7:0] ASCII_BANG = 8'h21;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_1    = 8'h31;
    localparam logic [7:0] ASCII_8    = 8'h38;

    // Bytes 0..4 of a good packet sum to this value modulo 256
    localparam logic [7:0] CSUM_TARGET = 8'hFF;

    // Button indices of the directional pad within o_buttons
    localparam logic [2:0] BTN_UP    = 3'd4;
    localparam logic [2:0] BTN_DOWN  = 3'd5;
    localparam logic [2:0] BTN_LEFT  = 3'd6;
    localparam logic [2:0] BTN_RIGHT = 3'd7;

endpackage

// File: rtl/bt_pad_decoder.sv
// Decodes 5-byte "!B<digit><action><csum>" control-pad packets into held button state.
// Latency: outputs update on the edge that samples the checksum byte (1 cycle after i_done).
// No backpressure: accepts one byte per cycle; stalled packets are abandoned after a timeout.
module bt_pad_decoder
    import bt_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int TIMEOUT_MS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_done,
    output logic [7:0] o_buttons,
    output logic       o_event,
    output logic [2:0] o_btn_id,
    output logic       o_pressed,
    output logic       o_err
);

    localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
    // The counter only has to hold TIMEOUT_CYC-1: expiry fires on the edge that would reach TIMEOUT_CYC
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state;
    logic [7:0]       sum;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       id;
    logic             act;
    logic [7:0]       sum_next;

    // Running checksum including the byte currently on i_data
    always_comb begin
        sum_next = sum + i_data;
    end

    // Packet parser, checksum accumulation, output update and inter-byte timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            sum       <= 8'h00;
            tmo_cnt   <= '0;
            id        <= 3'd0;
            act       <= 1'b0;
            o_buttons <= 8'h00;
            o_event   <= 1'b0;
            o_btn_id  <= 3'd0;
            o_pressed <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_event <= 1'b0;
            o_err   <= 1'b0;
            if (i_done) begin
                // A byte always wins over a coinciding timeout expiry
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (i_data == ASCII_BANG) begin
                            state <= ST_TYPE;
                            sum   <= ASCII_BANG;
                        end
                    end
                    ST_TYPE: begin
                        if (i_data == ASCII_B) begin
                            state <= ST_BTN;
                            sum   <= sum_next;
                        end else if (i_data == ASCII_BANG) begin
                            sum   <= ASCII_BANG;
                        end else begin
                            state <= ST_IDLE;
                            o_err <= 1'b1;
                        end
                    end
                    ST_BTN: begin
                        if (i_data >= ASCII_1 && i_data <= ASCII_8) begin
                            state <= ST_ACT;
                            sum   <= sum_next;
                            id    <= 3'(i_data - ASCII_1);
                        end else if (i_data == ASCII_BANG) begin
                            state <= ST_TYPE;
                            sum   <= ASCII_BANG;
                        end else begin
                            state <= ST_IDLE;
                            o_err <= 1'b1;
                        end
                    end
                    ST_ACT: begin
                        if (i_data == ASCII_0 || i_data == ASCII_1) begin
                            state <= ST_CSUM;
                            sum   <= sum_next;
                            act   <= i_data[0];
                        end else if (i_data == ASCII_BANG) begin
                            state <= ST_TYPE;
                            sum   <= ASCII_BANG;
                        end else begin
                            state <= ST_IDLE;
                            o_err <= 1'b1;
                        end
                    end
                    ST_CSUM: begin
                        // Any value is a checksum here, including '!'
                        state <= ST_IDLE;
                        if (sum_next == CSUM_TARGET) begin
                            o_buttons[id] <= act;
                            o_event       <= 1'b1;
                            o_btn_id      <= id;
                            o_pressed     <= act;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == CNT_LAST) begin
                    state   <= ST_IDLE;
                    o_err   <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bt_pad_decoder.sv
// Self-checking bench for bt_pad_decoder: directed packets plus randomized packet streams.
// Outputs compared every cycle, 1 time unit after the rising edge, against a byte-position model.
// Inputs change on the falling edge; no backpressure exists to exercise.
module tb_bt_pad_decoder;

    localparam int CLK_FREQ   = 100000;
    localparam int TIMEOUT_MS = 1;
    localparam int TMO        = CLK_FREQ / 1000 * TIMEOUT_MS;   // 100 cycles

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_done = 1'b0;
    logic [7:0] o_buttons;
    logic       o_event;
    logic [2:0] o_btn_id;
    logic       o_pressed;
    logic       o_err;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    bt_pad_decoder #(.CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_done    (i_done),
        .o_buttons (o_buttons),
        .o_event   (o_event),
        .o_btn_id  (o_btn_id),
        .o_pressed (o_pressed),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checksum byte that makes a well-formed packet for button index id and action a
    function automatic logic [7:0] csum_for(input int id, input int a);
        int s;
        s = 'h21 + 'h42 + ('h31 + id) + ('h30 + a);
        return 8'((255 - (s % 256)) % 256);
    endfunction

    // ---------------- behavioural model ----------------
    // The partial packet is kept as the list of bytes accepted so far;
    // its length alone says which byte comes next.
    logic [7:0] pkt[$];
    int         gap = 0;
    logic [7:0] m_buttons = 8'h00;
    logic [2:0] m_id = 3'd0;
    logic       m_pressed = 1'b0;
    logic       m_event = 1'b0;
    logic       m_err = 1'b0;

    task automatic model_byte(input logic [7:0] b);
        int  s;
        bit  ok;
        if (pkt.size() == 0) begin
            if (b == 8'h21) pkt.push_back(b);
        end else if (pkt.size() == 4) begin
            s = b;
            foreach (pkt[k]) s += pkt[k];
            if ((s % 256) == 255) begin
                m_buttons[pkt[2] - 8'h31] = pkt[3][0];
                m_id      = 3'(pkt[2] - 8'h31);
                m_pressed = pkt[3][0];
                m_event   = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            pkt.delete();
        end else begin
            ok = (pkt.size() == 1 && b == 8'h42) ||
                 (pkt.size() == 2 && b >= 8'h31 && b <= 8'h38) ||
                 (pkt.size() == 3 && (b == 8'h30 || b == 8'h31));
            if (ok) begin
                pkt.push_back(b);
            end else if (b == 8'h21) begin
                pkt.delete();
                pkt.push_back(b);
            end else begin
                m_err = 1'b1;
                pkt.delete();
            end
        end
    endtask

    // Model advance on every edge, then the single per-cycle compare
    always @(posedge i_clk) begin
        m_event = 1'b0;
        m_err   = 1'b0;
        if (i_rst) begin
            pkt.delete();
            gap = 0;
            m_buttons = 8'h00;
            m_id = 3'd0;
            m_pressed = 1'b0;
        end else if (i_done) begin
            model_byte(i_data);
            gap = 0;
        end else if (pkt.size() != 0) begin
            gap++;
            if (gap == TMO) begin
                m_err = 1'b1;
                pkt.delete();
                gap = 0;
            end
        end
        #1;
        if (check_en) begin
            chk("cyc_buttons", o_buttons, m_buttons);
            chk("cyc_event",   o_event,   m_event);
            chk("cyc_err",     o_err,     m_err);
            chk("cyc_btn_id",  o_btn_id,  m_id);
            chk("cyc_pressed", o_pressed, m_pressed);
            chk("cyc_evt_err_excl", o_event & o_err, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic d, input logic [7:0] b);
        @(negedge i_clk);
        i_rst  = r;
        i_done = d;
        i_data = b;
        @(posedge i_clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input int idle_after);
        step(1'b0, 1'b1, b);
        repeat (idle_after) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_pkt(input int id, input int a, input int idle_gap);
        send(8'h21, idle_gap);
        send(8'h42, idle_gap);
        send(8'(8'h31 + id), idle_gap);
        send(8'(8'h30 + a), idle_gap);
        send(csum_for(id, a), 0);
    endtask

    initial begin
        logic [7:0] pk [5];
        int id, a, r, g;

        // Reset state
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_en = 1'b1;
        chk("rst_buttons", o_buttons, 8'h00);
        chk("rst_event",   o_event,   0);
        chk("rst_err",     o_err,     0);
        chk("rst_btn_id",  o_btn_id,  0);
        chk("rst_pressed", o_pressed, 0);
        step(1'b0, 1'b0, 8'h00);

        // Model pins: hand-computed checksums
        chk("pin_csum_5_press", csum_for(4, 1), 8'h36);
        chk("pin_csum_5_rel",   csum_for(4, 0), 8'h37);
        chk("pin_csum_8_press", csum_for(7, 1), 8'h33);

        // Valid press of button 5 (up)
        send(8'h21, 1); send(8'h42, 1); send(8'h35, 1); send(8'h31, 1); send(8'h36, 0);
        chk("press_event",   o_event,   1);
        chk("press_buttons", o_buttons, 8'h10);
        chk("press_id",      o_btn_id,  4);
        chk("press_pressed", o_pressed, 1);
        chk("press_err",     o_err,     0);
        step(1'b0, 1'b0, 8'h00);
        chk("press_event_1cyc", o_event, 0);

        // Release
        send(8'h21, 0); send(8'h42, 0); send(8'h35, 0); send(8'h30, 0); send(8'h37, 0);
        chk("rel_buttons", o_buttons, 8'h00);
        chk("rel_pressed", o_pressed, 0);

        // Bad checksum
        send(8'h21, 0); send(8'h42, 0); send(8'h31, 0); send(8'h31, 0); send(8'h00, 0);
        chk("badcs_err",     o_err,     1);
        chk("badcs_event",   o_event,   0);
        chk("badcs_buttons", o_buttons, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("badcs_err_1cyc", o_err, 0);

        // Garbage, then resync inside the packet
        send(8'h55, 0);
        chk("garbage_silent", o_err, 0);
        send(8'h21, 0); send(8'h42, 0); send(8'h21, 0);
        chk("resync_silent", o_err, 0);
        send(8'h42, 0); send(8'h38, 0); send(8'h31, 0); send(8'h33, 0);
        chk("resync_event",   o_event,   1);
        chk("resync_buttons", o_buttons, 8'h80);

        // Out-of-range digit
        send(8'h21, 0); send(8'h42, 0); send(8'h39, 0);
        chk("range_err", o_err, 1);

        // Timeout after "!B"
        send(8'h21, 0); send(8'h42, TMO - 1);
        chk("tmo_not_yet", o_err, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("tmo_err", o_err, 1);
        send_pkt(0, 1, 0);
        chk("after_tmo_buttons", o_buttons, 8'h81);

        // Byte arriving on the expiry edge wins
        send(8'h21, TMO - 1);
        send(8'h42, 0);
        chk("byte_wins_err", o_err, 0);
        send(8'h32, 0); send(8'h31, 0); send(csum_for(1, 1), 0);
        chk("byte_wins_buttons", o_buttons, 8'h83);

        // Reset between bytes 3 and 4
        send(8'h21, 0); send(8'h42, 0); send(8'h33, 0);
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_buttons", o_buttons, 8'h00);
        chk("midrst_id",      o_btn_id,  0);
        chk("midrst_pressed", o_pressed, 0);
        send(8'h31, 0); send(csum_for(2, 1), 0);
        chk("midrst_discard", o_buttons, 8'h00);

        // Back-to-back packets, no idle gap, plus repeated press
        send_pkt(2, 1, 0);
        send_pkt(6, 1, 0);
        chk("b2b_buttons", o_buttons, 8'h44);
        send_pkt(6, 1, 0);
        chk("repeat_event",   o_event,   1);
        chk("repeat_buttons", o_buttons, 8'h44);

        // Randomized packet stream with corruption, stalls and occasional resets
        for (int p = 0; p < 300; p++) begin
            id = $urandom_range(0, 7);
            a  = $urandom_range(0, 1);
            pk[0] = 8'h21;
            pk[1] = 8'h42;
            pk[2] = 8'(8'h31 + id);
            pk[3] = 8'(8'h30 + a);
            pk[4] = csum_for(id, a);
            r = $urandom_range(0, 99);
            if (r < 15)
                pk[$urandom_range(1, 4)] = 8'($urandom);
            else if (r < 20)
                pk[$urandom_range(1, 4)] = 8'h21;
            else if (r < 25)
                send(8'($urandom), 0);
            if ($urandom_range(0, 49) == 0)
                step(1'b1, 1'b0, 8'h00);
            for (int i = 0; i < 5; i++) begin
                g = ($urandom_range(0, 29) == 0) ? $urandom_range(TMO - 5, TMO + 5)
                                                 : $urandom_range(0, 2);
                repeat (g) step(1'b0, 1'b0, 8'($urandom));
                step(1'b0, 1'b1, pk[i]);
            end
        end
        repeat (3) step(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
